down_count_ctrl: RTL and testbench

//  Loadable down-counter controller that consumes the registered word from the upstream 2:1 mux-register stage.
//  On start it latches that word, counts it down to zero on enabled cycles and pulses done.

---
 rtl/down_count_ctrl_pkg.sv | 24 ++
 rtl/down_count_ctrl_cell.sv | 22 ++
 rtl/down_count_ctrl.sv | 85 ++++++++
 tb/tb_down_count_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/down_count_ctrl_pkg.sv
// Shared types for the down-count controller: state encodings and next-count select.
// Optional feature macro: AUTO_RELOAD_EN (restart directly from DONE).
package down_count_ctrl_pkg;

    localparam int DCC_STATE_W = 2;

    typedef enum logic [DCC_STATE_W-1:0] {
        DCC_IDLE  = 2'b00,
        DCC_LOAD  = 2'b01,
        DCC_COUNT = 2'b10,
        DCC_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_DEC  = 2'b10
    } sel_t;

    function automatic logic is_busy(input state_t s);
        return (s == DCC_LOAD) || (s == DCC_COUNT);
    endfunction

endpackage

// File: rtl/down_count_ctrl_cell.sv
// Per-bit next-count mux: hold, load, or decrement using the incoming borrow.
// Instantiated once per counter bit by down_count_ctrl.
module count_next_cell
    import down_count_ctrl_pkg::*;
(
    input  sel_t sel,
    input  logic cur,
    input  logic ld,
    input  logic bin,
    output logic nxt
);

    always_comb begin
        nxt = cur;
        unique case (sel)
            SEL_LOAD: nxt = ld;
            SEL_DEC:  nxt = cur ^ bin;
            default:  nxt = cur;
        endcase
    end

endmodule

// File: rtl/down_count_ctrl.sv
// Loadable down-counter controller: latch on start, count down on enable, pulse done.
// Define AUTO_RELOAD_EN to allow start in DONE to begin the next run immediately.
module down_count_ctrl
    import down_count_ctrl_pkg::*;
#(
    parameter int bits = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            enable,
    input  logic [bits-1:0] load_value,
    output logic [bits-1:0] count,
    output logic            busy,
    output logic            done
);

    state_t            state;
    sel_t              sel;
    logic [bits-1:0]   borrow;
    logic [bits-1:0]   count_nxt;

    always_comb begin
        sel = SEL_HOLD;
        unique case (1'b1)
            state == DCC_LOAD:              sel = SEL_LOAD;
            state == DCC_COUNT && enable:   sel = SEL_DEC;
            default:                        sel = SEL_HOLD;
        endcase
    end

    // Ripple borrow for count-1; bit 0 always subtracts.
    always_comb begin
        borrow[0] = 1'b1;
        for (int i = 1; i < bits; i++)
            borrow[i] = borrow[i-1] & ~count[i-1];
    end

    for (genvar g = 0; g < bits; g++) begin : g_cell
        count_next_cell u_cell (
            .sel (sel),
            .cur (count[g]),
            .ld  (load_value[g]),
            .bin (borrow[g]),
            .nxt (count_nxt[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DCC_IDLE;
            count <= '0;
        end else begin
            count <= count_nxt;
            unique case (state)
                DCC_IDLE: begin
                    if (start)
                        state <= DCC_LOAD;
                end
                DCC_LOAD: begin
                    if (load_value == '0)
                        state <= DCC_DONE;
                    else
                        state <= DCC_COUNT;
                end
                DCC_COUNT: begin
                    if (enable && count == bits'(1))
                        state <= DCC_DONE;
                end
                DCC_DONE: begin
`ifdef AUTO_RELOAD_EN
                    state <= start ? DCC_LOAD : DCC_IDLE;
`else
                    state <= DCC_IDLE;
`endif
                end
                default: state <= DCC_IDLE;
            endcase
        end
    end

    assign busy = is_busy(state);
    assign done = (state == DCC_DONE);

endmodule

// File: tb/tb_down_count_ctrl.sv
// Self-checking bench for down_count_ctrl: directed table, corner sequences, random vs model.
// Honours AUTO_RELOAD_EN in both the model and the directed reload sequence.
module tb_down_count_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] load_value = 3'd0;
    logic [2:0] count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    down_count_ctrl #(.bits(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .load_value (load_value),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       r;
        logic       s;
        logic       e;
        logic [2:0] lv;
        logic [2:0] c;
        logic       b;
        logic       d;
    } vec_t;

    vec_t tbl [26];

    // Behavioural model: a run is "pending load", "counting", or "done pulse".
    bit m_pend, m_run, m_done;
    int m_cnt;

    task automatic model_edge(input logic r, input logic s,
                              input logic e, input logic [2:0] lv);
        if (r) begin
            m_pend = 0; m_run = 0; m_done = 0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 0;
`ifdef AUTO_RELOAD_EN
            if (s) m_pend = 1;
`endif
        end else if (m_pend) begin
            m_pend = 0;
            m_cnt = int'(lv);
            if (m_cnt == 0) m_done = 1;
            else m_run = 1;
        end else if (m_run) begin
            if (e) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end else if (s) begin
            m_pend = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s,
                        input logic e, input logic [2:0] lv);
        reset = r; start = s; enable = e; load_value = lv;
        @(posedge clock);
        model_edge(r, s, e, lv);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, int'(count), m_cnt);
        chk({tag, ".busy"}, int'(busy), int'(m_pend | m_run));
        chk({tag, ".done"}, int'(done), int'(m_done));
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic e,
                                input int lv, input int c,
                                input logic b, input logic d);
        vec_t v;
        v.r = r; v.s = s; v.e = e;
        v.lv = 3'(lv); v.c = 3'(c); v.b = b; v.d = d;
        return v;
    endfunction

    initial begin
        // load 5, enable high
        tbl[0]  = mk(0,1,1,5, 0,1,0);
        tbl[1]  = mk(0,0,1,5, 5,1,0);
        tbl[2]  = mk(0,0,1,5, 4,1,0);
        tbl[3]  = mk(0,0,1,5, 3,1,0);
        tbl[4]  = mk(0,0,1,5, 2,1,0);
        tbl[5]  = mk(0,0,1,5, 1,1,0);
        tbl[6]  = mk(0,0,1,5, 0,0,1);
        tbl[7]  = mk(0,0,1,5, 0,0,0);
        // load 0
        tbl[8]  = mk(0,1,1,0, 0,1,0);
        tbl[9]  = mk(0,0,1,0, 0,0,1);
        tbl[10] = mk(0,0,1,0, 0,0,0);
        // load 3, enable 1,0,0,1,1
        tbl[11] = mk(0,1,0,3, 0,1,0);
        tbl[12] = mk(0,0,0,3, 3,1,0);
        tbl[13] = mk(0,0,1,3, 2,1,0);
        tbl[14] = mk(0,0,0,3, 2,1,0);
        tbl[15] = mk(0,0,0,3, 2,1,0);
        tbl[16] = mk(0,0,1,3, 1,1,0);
        tbl[17] = mk(0,0,1,3, 0,0,1);
        tbl[18] = mk(0,0,0,3, 0,0,0);
        // load 7, restart ignored, reset at 4
        tbl[19] = mk(0,1,1,7, 0,1,0);
        tbl[20] = mk(0,0,1,7, 7,1,0);
        tbl[21] = mk(0,1,1,2, 6,1,0);
        tbl[22] = mk(0,1,1,2, 5,1,0);
        tbl[23] = mk(0,0,1,2, 4,1,0);
        tbl[24] = mk(1,0,1,2, 0,0,0);
        tbl[25] = mk(0,0,1,2, 0,0,0);

        // reset for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 3'($urandom));
            chk("reset.count", int'(count), 0);
            chk("reset.busy", int'(busy), 0);
            chk("reset.done", int'(done), 0);
        end
        step(0, 0, 0, 0);
        chk("idle.busy", int'(busy), 0);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].lv);
            chk($sformatf("tbl%0d.count", i), int'(count), int'(tbl[i].c));
            chk($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].b));
            chk($sformatf("tbl%0d.done", i), int'(done), int'(tbl[i].d));
        end

        // start held high with load 2: back-to-back runs or an idle gap
        for (int i = 0; i < 15; i++) begin
            int ph, ec;
            logic eb, ed;
            step(0, 1, 1, 2);
`ifdef AUTO_RELOAD_EN
            ph = i % 4;
`else
            ph = i % 5;
`endif
            ec = (ph == 1) ? 2 : (ph == 2) ? 1 : 0;
            eb = (ph <= 2);
            ed = (ph == 3);
            chk($sformatf("reload%0d.count", i), int'(count), ec);
            chk($sformatf("reload%0d.busy", i), int'(busy), int'(eb));
            chk($sformatf("reload%0d.done", i), int'(done), int'(ed));
        end

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_model("rst2");

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) != 0),
                 3'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
